// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the 4-bit XNOR LFSR stream checker family.
// State encoding, history tap positions, stream period and the reference
// sequence (bit i of LFSR_REF_SEQ is stream bit s[i]).
package lfsr_pkg;

    localparam int LFSR_W      = 4;
    localparam int TAP_A       = 3;
    localparam int TAP_B       = 2;
    localparam int LFSR_PERIOD = 15;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_SYNC = 2'd1,
        ST_LOCK = 2'd2
    } chk_state_e;

    // s[0..14] = 0,1,1,1,0,1,1,0,0,1,0,1,0,0,0 (LSB is s[0])
    localparam logic [LFSR_PERIOD-1:0] LFSR_REF_SEQ = 15'b000101001101110;

    // Next stream bit from the history: s[n] = ~(s[n-4] ^ s[n-3]).
    function automatic logic lfsr_next(input logic [LFSR_W-1:0] hist);
        return ~(hist[TAP_A] ^ hist[TAP_B]);
    endfunction

endpackage

// File: rtl/lfsr_stream_checker_predictor.sv
// lfsr_predictor: 4-bit receive history shift register with XNOR next-bit
// prediction. hist[0] is the newest bit, hist[3] the oldest. Also flags the
// all-ones history, which is the XNOR lock-up pattern.
module lfsr_predictor
    import lfsr_pkg::*;
(
    input  logic clk,
    input  logic clr,
    input  logic shift_en,
    input  logic din,
    output logic match,
    output logic hist_ones
);

    logic [LFSR_W-1:0] hist_d;
    logic [LFSR_W-1:0] hist_q;
    logic              pred;

    // Shift in every qualified bit so the history always re-seeds from the line.
    always_comb begin
        hist_d = hist_q;
        if (shift_en) begin
            hist_d = {hist_q[LFSR_W-2:0], din};
        end
    end

    // History register, cleared asynchronously.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign pred      = lfsr_next(hist_q);
    assign match     = (din == pred);
    assign hist_ones = &hist_q;

endmodule

// File: rtl/lfsr_stream_checker.sv
// lfsr_stream_checker: self-synchronising checker for the 4-bit XNOR LFSR
// stream. HUNT fills the history, SYNC counts SYNC_N consecutive correct
// predictions, LOCK flags/counts mismatches and drops back to HUNT after
// LOSS_N consecutive mismatches.
// Optional macro LFSR_CHK_LOCKUP_EN: an all-ones history in SYNC/LOCK forces
// HUNT on the next valid bit and sets the sticky lockup output.
module lfsr_stream_checker
    import lfsr_pkg::*;
#(
    parameter int SYNC_N = 8,
    parameter int LOSS_N = 4,
    parameter int ERR_W  = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             din,
    input  logic             din_valid,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
`ifdef LFSR_CHK_LOCKUP_EN
    output logic             lockup,
`endif
    output logic [1:0]       state
);

    localparam logic [7:0]       SYNC_TGT = 8'(SYNC_N);
    localparam logic [7:0]       LOSS_TGT = 8'(LOSS_N);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    chk_state_e       state_d, state_q;
    logic [2:0]       fill_d, fill_q;
    logic [7:0]       run_d, run_q;
    logic [7:0]       run_inc;
    logic [ERR_W-1:0] err_cnt_d, err_cnt_q;
    logic             err_pulse_d, err_pulse_q;
    logic             locked_d, locked_q;
    logic             lockup_d, lockup_q;
    logic             err_hit;
    logic             lockup_hit;
    logic             match;
    logic             hist_ones;

    lfsr_predictor u_pred (
        .clk       (clk),
        .clr       (clr),
        .shift_en  (din_valid),
        .din       (din),
        .match     (match),
        .hist_ones (hist_ones)
    );

`ifdef LFSR_CHK_LOCKUP_EN
    assign lockup_hit = hist_ones && (state_q != ST_HUNT);
`else
    logic unused_hist_ones;
    assign unused_hist_ones = hist_ones;
    assign lockup_hit       = 1'b0;
`endif

    assign run_inc = run_q + 8'd1;

    // Next-state, counter and output decisions for the bit presented this cycle.
    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        run_d       = run_q;
        err_cnt_d   = err_cnt_q;
        err_pulse_d = 1'b0;
        lockup_d    = lockup_q;
        err_hit     = 1'b0;
        if (din_valid) begin
            if (lockup_hit) begin
                // Stuck in the XNOR lock-up pattern: restart acquisition.
                state_d  = ST_HUNT;
                fill_d   = 3'd0;
                run_d    = 8'd0;
                lockup_d = 1'b1;
            end else begin
                case (state_q)
                    ST_HUNT: begin
                        fill_d = fill_q + 3'd1;
                        if (fill_q == 3'(LFSR_W - 1)) begin
                            state_d = ST_SYNC;
                            run_d   = 8'd0;
                        end
                    end
                    ST_SYNC: begin
                        if (match) begin
                            run_d = run_inc;
                            if (run_inc == SYNC_TGT) begin
                                state_d = ST_LOCK;
                                run_d   = 8'd0;
                            end
                        end else begin
                            run_d = 8'd0;
                        end
                    end
                    ST_LOCK: begin
                        if (match) begin
                            run_d = 8'd0;
                        end else begin
                            err_hit     = 1'b1;
                            err_pulse_d = 1'b1;
                            run_d       = run_inc;
                            if (run_inc == LOSS_TGT) begin
                                state_d = ST_HUNT;
                                fill_d  = 3'd0;
                                run_d   = 8'd0;
                            end
                        end
                    end
                    default: begin
                        state_d = ST_HUNT;
                        fill_d  = 3'd0;
                        run_d   = 8'd0;
                    end
                endcase
            end
        end
        // Clear beats a simultaneous increment.
        if (err_clr) begin
            err_cnt_d = '0;
            lockup_d  = 1'b0;
        end else if (err_hit && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
        locked_d = (state_d == ST_LOCK);
    end

    // Checker state and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= ST_HUNT;
            fill_q      <= 3'd0;
            run_q       <= 8'd0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
            locked_q    <= 1'b0;
            lockup_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            run_q       <= run_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
            locked_q    <= locked_d;
            lockup_q    <= lockup_d;
        end
    end

    assign state     = state_q;
    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_cnt_q;
`ifdef LFSR_CHK_LOCKUP_EN
    assign lockup    = lockup_q;
`else
    logic unused_lockup_q;
    assign unused_lockup_q = lockup_q;
`endif

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Scoreboard bench for lfsr_stream_checker. A 16-bit instance and a 2-bit
// counter instance (saturates at 3) share the same inputs.
// Build with +define+LFSR_CHK_LOCKUP_EN to exercise the lock-up option.
module tb_lfsr_stream_checker;
    import lfsr_pkg::*;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic        err_clr = 1'b0;
    logic        locked, err_pulse, locked_s, err_pulse_s;
    logic [15:0] err_count;
    logic [1:0]  err_count_s;
    logic [1:0]  state, state_s;
    logic        lockup = 1'b0;
    logic        lockup_s = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0]  st;
        logic        lk;
        logic        ep;
        logic [15:0] ec;
        logic [1:0]  ecs;
        logic        lu;
    } exp_t;

    exp_t sb[$];

    // reference model state
    logic [3:0] m_hist  = 4'd0;
    int         m_state = 0;
    int         m_fill  = 0;
    int         m_run   = 0;
    int         m_cnt   = 0;
    int         m_cnt_s = 0;
    logic       m_pulse = 1'b0;
    logic       m_lu    = 1'b0;

    lfsr_stream_checker #(.SYNC_N(8), .LOSS_N(4), .ERR_W(16)) dut (
        .clk       (clk),
        .clr       (clr),
        .din       (din),
        .din_valid (din_valid),
        .err_clr   (err_clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
`ifdef LFSR_CHK_LOCKUP_EN
        .lockup    (lockup),
`endif
        .state     (state)
    );

    lfsr_stream_checker #(.SYNC_N(8), .LOSS_N(4), .ERR_W(2)) dut_s (
        .clk       (clk),
        .clr       (clr),
        .din       (din),
        .din_valid (din_valid),
        .err_clr   (err_clr),
        .locked    (locked_s),
        .err_pulse (err_pulse_s),
        .err_count (err_count_s),
`ifdef LFSR_CHK_LOCKUP_EN
        .lockup    (lockup_s),
`endif
        .state     (state_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist = 4'd0; m_state = 0; m_fill = 0; m_run = 0;
        m_cnt = 0; m_cnt_s = 0; m_pulse = 1'b0; m_lu = 1'b0;
    endtask

    task automatic model_step(input logic b, input logic v, input logic ec);
        logic pred;
        logic hit;
        logic lu_hit;
        hit = 1'b0;
        lu_hit = 1'b0;
        if (v) begin
            pred = ~(m_hist[3] ^ m_hist[2]);
`ifdef LFSR_CHK_LOCKUP_EN
            if (m_state != 0 && m_hist == 4'hF) begin
                lu_hit = 1'b1; m_state = 0; m_fill = 0; m_run = 0;
            end else
`endif
            begin
                if (m_state == 0) begin
                    m_fill++;
                    if (m_fill == 4) begin m_state = 1; m_run = 0; end
                end else if (m_state == 1) begin
                    if (b == pred) begin
                        m_run++;
                        if (m_run == 8) begin m_state = 2; m_run = 0; end
                    end else m_run = 0;
                end else begin
                    if (b == pred) m_run = 0;
                    else begin
                        hit = 1'b1;
                        m_run++;
                        if (m_run == 4) begin m_state = 0; m_fill = 0; m_run = 0; end
                    end
                end
            end
            m_hist = {m_hist[2:0], b};
        end
        m_pulse = hit;
        if (ec) begin
            m_cnt = 0; m_cnt_s = 0; m_lu = 1'b0;
        end else begin
            if (hit && m_cnt < 65535) m_cnt++;
            if (hit && m_cnt_s < 3) m_cnt_s++;
            if (lu_hit) m_lu = 1'b1;
        end
    endtask

    // Drive one cycle of stimulus and queue the expected post-edge outputs.
    task automatic step(input logic b, input logic v, input logic ec);
        exp_t e;
        @(negedge clk);
        din = b; din_valid = v; err_clr = ec;
        model_step(b, v, ec);
        e.st = 2'(m_state); e.lk = (m_state == 2); e.ep = m_pulse;
        e.ec = 16'(m_cnt); e.ecs = 2'(m_cnt_s); e.lu = m_lu;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once.
    task automatic do_reset(input string tag);
        @(negedge clk);
        din_valid = 1'b0; err_clr = 1'b0;
        #2;
        clr = 1'b1;
        model_reset();
        #1;
        chk({tag, "_state"}, state, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_err_pulse"}, err_pulse, 0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_err_count_s"}, err_count_s, 0);
        chk({tag, "_lockup"}, lockup, 0);
        clr = 1'b0;
    endtask

    // Monitor: compare every queued expectation just after its clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_state", state, e.st);
                chk("sb_locked", locked, e.lk);
                chk("sb_err_pulse", err_pulse, e.ep);
                chk("sb_err_count", err_count, e.ec);
                chk("sb_err_count_s", err_count_s, e.ecs);
                chk("sb_state_s", state_s, e.st);
`ifdef LFSR_CHK_LOCKUP_EN
                chk("sb_lockup", lockup, e.lu);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] refseq;
        logic        b;
        int          pos;
        refseq = LFSR_REF_SEQ;

        // reset state while clr held from time zero
        #2;
        chk("rst_state", state, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_err_count", err_count, 0);
        @(negedge clk);
        clr = 1'b0;

        // two periods from s0, bit 20 inverted
        for (int i = 0; i < 30; i++) begin
            b = refseq[i % 15];
            if (i == 20) b = ~b;
            step(b, 1'b1, 1'b0);
            if (i == 2)  chk("hunt_after_3", state, 0);
            if (i == 3)  chk("sync_after_4", state, 1);
            if (i == 10) chk("unlocked_after_11", locked, 0);
            if (i == 11) chk("locked_after_12", locked, 1);
            if (i == 19) chk("no_err_before_20", err_count, 0);
            if (i == 20) begin
                chk("err_pulse_bit20", err_pulse, 1);
                chk("err_count_bit20", err_count, 1);
                chk("locked_bit20", locked, 1);
            end
            if (i == 21) chk("err_pulse_clears", err_pulse, 0);
        end
        chk("err_count_after_corrupt", err_count, 3);
        chk("err_count_s_sat3", err_count_s, 3);

        // saturation and clear-beats-increment
        for (int i = 30; i < 45; i++) begin
            b = refseq[i % 15];
            if (i == 35) b = ~b;
            step(b, 1'b1, (i == 38));
            if (i == 35) begin
                chk("cnt_inc_bit35", err_count, 4);
                chk("cnt_s_saturated", err_count_s, 3);
            end
            if (i == 38) begin
                chk("clr_wins_cnt", err_count, 0);
                chk("clr_wins_cnt_s", err_count_s, 0);
            end
        end
        chk("cnt_after_clear", err_count, 1);
        chk("still_locked_45", locked, 1);

        // zeros in LOCK: loss on fourth consecutive mismatch
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, 1'b0);
            if (k == 3) chk("locked_before_loss", locked, 1);
            if (k == 4) begin
                chk("loss_locked", locked, 0);
                chk("loss_state_hunt", state, 0);
                chk("loss_err_count", err_count, 5);
            end
        end
        chk("zeros_end_sync", state, 1);
        chk("zeros_end_unlocked", locked, 0);

        // mid-period start with idle cycles interleaved
        do_reset("rst1");
        for (int j = 0; j < 24; j++) begin
            if (j % 2 == 0) step(refseq[(7 + j / 2) % 15], 1'b1, 1'b0);
            else            step(~refseq[(8 + j / 2) % 15], 1'b0, 1'b0);
            if (j == 6)  chk("mid_sync_after_4", state, 1);
            if (j == 20) chk("mid_unlocked_11", locked, 0);
            if (j == 22) chk("mid_locked_12", locked, 1);
        end
        chk("mid_idle_locked", locked, 1);
        chk("mid_no_errors", err_count, 0);

        // reset in LOCK, then relock from s26
        for (pos = 19; pos < 26; pos++) step(refseq[pos % 15], 1'b1, 1'b0);
        chk("pre_reset_locked", locked, 1);
        do_reset("rst2");
        for (int k = 0; k < 12; k++) begin
            step(refseq[(26 + k) % 15], 1'b1, 1'b0);
            if (k == 10) chk("relock_not_11", locked, 0);
            if (k == 11) chk("relock_12", locked, 1);
        end

        // constant ones after lock
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0);
        chk("ones_err_count", err_count, 3);
`ifdef LFSR_CHK_LOCKUP_EN
        chk("lockup_set", lockup, 1);
        chk("lockup_state_hunt", state, 0);
        step(1'b1, 1'b0, 1'b1);
        chk("lockup_cleared", lockup, 0);
`else
        chk("ones_locked", locked, 1);
        chk("ones_state_lock", state, 2);
        step(1'b1, 1'b0, 1'b1);
`endif
        chk("final_err_clr", err_count, 0);

        step(1'b0, 1'b0, 1'b0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
